// File: rtl/alu_result_disp.sv
// ============================================================================
// Module      : alu_result_disp
// Description : Display stage for the 4-bit signed ALU. Captures one result
//               per valid/ready handshake, holds it for a minimum display
//               time and drives a 3-digit multiplexed active-low 7-segment
//               display (func code, sign, magnitude).
//               Optional macro ALU_DISP_BLINK_EN: blink the display when the
//               captured flag is set.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_result_disp #(
    parameter int SCAN_DIV    = 1000,      // cycles per digit, >= 2
    parameter int HOLD_CYCLES = 50000000   // cycles in_ready stays low, >= 1
) (
    input  logic       clk,
    input  logic       rst,                // asynchronous, active-low
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_result,
    input  logic [2:0] in_func,
    input  logic       in_flag,
    output logic [7:0] seg_n,
    output logic [2:0] an_n,
    output logic       flag_led
);

    localparam int                c_HOLD_W    = $clog2(HOLD_CYCLES + 1);
    localparam int                c_PRE_W     = $clog2(SCAN_DIV);
    localparam logic [c_HOLD_W-1:0] c_HOLD_LOAD = c_HOLD_W'(HOLD_CYCLES);
    localparam logic [c_PRE_W-1:0]  c_PRE_MAX   = c_PRE_W'(SCAN_DIV - 1);

    // Digit index encoding
    localparam logic [1:0] c_DIG_MAG  = 2'd0;
    localparam logic [1:0] c_DIG_SIGN = 2'd1;
    localparam logic [1:0] c_DIG_FUNC = 2'd2;

    localparam logic [7:0] c_SEG_BLANK = 8'hFF;
    localparam logic [7:0] c_SEG_MINUS = 8'hBF;

    logic [3:0]          r_result;
    logic [2:0]          r_func;
    logic                r_flag;
    logic [c_HOLD_W-1:0] r_hold;
    logic [c_PRE_W-1:0]  r_pre;
    logic [1:0]          r_idx;
    logic [7:0]          r_seg_n;
    logic [2:0]          r_an_n;

    logic                w_capture;
    logic                w_pre_wrap;
    logic                w_blank;
    logic                w_is_arith;
    logic [3:0]          w_mag;
    logic [3:0]          w_mag_val;
    logic [7:0]          w_seg_next;
    logic [2:0]          w_an_next;

    // Hex digit to active-low segment pattern; dp (bit 7) always off
    function automatic logic [7:0] f_seg7(input logic [3:0] v);
        logic [7:0] s;
        case (v)
            4'h0: s = 8'hC0;
            4'h1: s = 8'hF9;
            4'h2: s = 8'hA4;
            4'h3: s = 8'hB0;
            4'h4: s = 8'h99;
            4'h5: s = 8'h92;
            4'h6: s = 8'h82;
            4'h7: s = 8'hF8;
            4'h8: s = 8'h80;
            4'h9: s = 8'h90;
            4'hA: s = 8'h88;
            4'hB: s = 8'h83;
            4'hC: s = 8'hC6;
            4'hD: s = 8'hA1;
            4'hE: s = 8'h86;
            default: s = 8'h8E;
        endcase
        return s;
    endfunction

    assign in_ready   = (r_hold == '0);
    assign w_capture  = in_valid && in_ready;
    assign w_pre_wrap = (r_pre == c_PRE_MAX);
    assign flag_led   = r_flag;
    assign seg_n      = r_seg_n;
    assign an_n       = r_an_n;

    // Capture register: latched only on an accepted handshake
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_result <= 4'd0;
            r_func   <= 3'd0;
            r_flag   <= 1'b0;
        end else if (w_capture) begin
            r_result <= in_result;
            r_func   <= in_func;
            r_flag   <= in_flag;
        end
    end

    // Hold counter: in_ready is low while non-zero
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hold <= '0;
        end else if (w_capture) begin
            r_hold <= c_HOLD_LOAD;
        end else if (r_hold != '0) begin
            r_hold <= r_hold - 1'b1;
        end
    end

    // Scan prescaler and digit index, independent of captures
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pre <= '0;
            r_idx <= c_DIG_MAG;
        end else if (w_pre_wrap) begin
            r_pre <= '0;
            r_idx <= (r_idx == c_DIG_FUNC) ? c_DIG_MAG : r_idx + 2'd1;
        end else begin
            r_pre <= r_pre + 1'b1;
        end
    end

`ifdef ALU_DISP_BLINK_EN
    logic [7:0] r_round;

    // Round counter: one count per full 3-digit scan
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_round <= 8'd0;
        end else if (w_pre_wrap && (r_idx == c_DIG_FUNC)) begin
            r_round <= r_round + 8'd1;
        end
    end

    assign w_blank = r_round[7] & r_flag;
`else
    assign w_blank = 1'b0;
`endif

    // Digit content decode from the captured data
    always_comb begin
        w_is_arith = (r_func[2:1] == 2'b00);
        // Magnitude of a 4-bit two's complement value; -8 yields 8, which
        // fits the unsigned 4-bit result, so no fifth bit is carried.
        w_mag      = r_result[3] ? (4'd0 - r_result) : r_result;
        if (w_is_arith) begin
            w_mag_val = w_mag;
        end else if (r_func[2:1] == 2'b11) begin
            w_mag_val = {3'b000, r_flag};
        end else begin
            w_mag_val = r_result;
        end

        case (r_idx)
            c_DIG_MAG:  w_seg_next = f_seg7(w_mag_val);
            c_DIG_SIGN: w_seg_next = (w_is_arith && r_result[3]) ? c_SEG_MINUS : c_SEG_BLANK;
            c_DIG_FUNC: w_seg_next = f_seg7({1'b0, r_func});
            default:    w_seg_next = c_SEG_BLANK;
        endcase

        case (r_idx)
            c_DIG_MAG:  w_an_next = 3'b110;
            c_DIG_SIGN: w_an_next = 3'b101;
            c_DIG_FUNC: w_an_next = 3'b011;
            default:    w_an_next = 3'b111;
        endcase
        if (w_blank) begin
            w_an_next = 3'b111;
        end
    end

    // Registered display outputs, one cycle behind index/data
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_seg_n <= c_SEG_BLANK;
            r_an_n  <= 3'b111;
        end else begin
            r_seg_n <= w_seg_next;
            r_an_n  <= w_an_next;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_result_disp.sv
// ============================================================================
// Module      : tb_alu_result_disp
// Description : Scoreboard bench for alu_result_disp (SCAN_DIV=4,
//               HOLD_CYCLES=8). Stimulus pushes expected digit frames; a
//               monitor pops them and compares each scanned digit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_result_disp;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_result = 4'd0;
    logic [2:0] in_func = 3'd0;
    logic       in_flag = 1'b0;
    logic [7:0] seg_n;
    logic [2:0] an_n;
    logic       flag_led;

    int errors = 0;
    int checks = 0;

    // Expected frame {func_seg, sign_seg, mag_seg}
    logic [23:0] exp_q[$];
    string       name_q[$];
    bit          mon_busy = 1'b0;

    alu_result_disp #(
        .SCAN_DIV    (4),
        .HOLD_CYCLES (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_result (in_result),
        .in_func   (in_func),
        .in_flag   (in_flag),
        .seg_n     (seg_n),
        .an_n      (an_n),
        .flag_led  (flag_led)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: for each expected frame, wait for each digit to be scanned
    initial begin
        logic [23:0] e;
        string       nm;
        logic [2:0]  ea;
        int          n;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e        = exp_q.pop_front();
                nm       = name_q.pop_front();
                mon_busy = 1'b1;
                for (int d = 0; d < 3; d++) begin
                    ea = 3'b111;
                    ea[d] = 1'b0;
                    n = 0;
                    while (an_n !== ea && n < 40) begin
                        @(negedge clk);
                        n++;
                    end
                    if (n >= 40)
                        chk($sformatf("%s_scan_timeout_d%0d", nm, d), {29'd0, an_n}, {29'd0, ea});
                    else
                        chk($sformatf("%s_d%0d", nm, d), {24'd0, seg_n}, {24'd0, e[8*d +: 8]});
                end
                mon_busy = 1'b0;
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || mon_busy) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("idle_timeout", exp_q.size(), 0);
    endtask

    task automatic wait_ready(input string nm);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_ready"}, {31'd0, in_ready}, 32'd1);
    endtask

    task automatic capture(input logic [3:0] res, input logic [2:0] fn, input logic fl,
                           input logic [23:0] exp, input string nm);
        @(negedge clk);
        wait_ready(nm);
        in_result = res;
        in_func   = fn;
        in_flag   = fl;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk({nm, "_ready_low"}, {31'd0, in_ready}, 32'd0);
        chk({nm, "_flag_led"}, {31'd0, flag_led}, {31'd0, fl});
        @(posedge clk);
        #1;
        exp_q.push_back(exp);
        name_q.push_back(nm);
        wait_idle();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        logic [2:0] ea;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_seg", {24'd0, seg_n}, 32'hFF);
        chk("rst_an", {29'd0, an_n}, 32'h7);
        chk("rst_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_flag", {31'd0, flag_led}, 32'd0);
        rst = 1'b1;

        // Scan order and dwell time, first frame shows '0'
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            ea = 3'b111;
            ea[(k / 4) % 3] = 1'b0;
            chk($sformatf("scan_an_%0d", k), {29'd0, an_n}, {29'd0, ea});
            if (k == 0) chk("post_rst_d0", {24'd0, seg_n}, 32'hC0);
        end

        // Directed captures
        capture(4'b1001, 3'b000, 1'b0, 24'hC0BFF8, "neg7_add");
        capture(4'b1000, 3'b001, 1'b0, 24'hF9BF80, "neg8_sub");
        capture(4'b1010, 3'b011, 1'b0, 24'hB0FF88, "hexA_f3");
        capture(4'b0000, 3'b110, 1'b1, 24'h82FFF9, "flag1_f6");
        capture(4'b0101, 3'b000, 1'b0, 24'hC0FF92, "pos5_add");
        capture(4'b1111, 3'b111, 1'b0, 24'hF8FFC0, "flag0_f7");
        capture(4'b1111, 3'b101, 1'b0, 24'h92FF8E, "hexF_f5");
        capture(4'b1110, 3'b001, 1'b0, 24'hF9BFA4, "neg2_sub");

        // Hold time with data changing during the hold
        @(negedge clk);
        wait_ready("hold");
        in_result = 4'b0011;
        in_func   = 3'b010;
        in_flag   = 1'b0;
        in_valid  = 1'b1;
        @(negedge clk);
        n = 0;
        while (!in_ready && n < 50) begin
            n++;
            if (n == 3) in_result = 4'b0110;
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("hold_low_cycles", n, 8);
        @(posedge clk);
        #1;
        exp_q.push_back(24'hA4FFB0);
        name_q.push_back("hold_ignore");
        wait_idle();

        // Back-to-back captures with in_valid held high
        @(negedge clk);
        wait_ready("b2b");
        in_result = 4'b0101;
        in_func   = 3'b100;
        in_valid  = 1'b1;
        for (int r = 0; r < 2; r++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!in_ready && n < 50);
            chk($sformatf("b2b_gap_%0d", r), n, 9);
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        exp_q.push_back(24'h99FF92);
        name_q.push_back("b2b_disp");
        wait_idle();

        // Reset pulse in the middle of a hold
        @(negedge clk);
        wait_ready("midhold");
        in_result = 4'b0000;
        in_func   = 3'b110;
        in_flag   = 1'b1;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("midhold_busy", {31'd0, in_ready}, 32'd0);
        rst = 1'b0;
        #1;
        chk("midhold_rst_ready", {31'd0, in_ready}, 32'd1);
        chk("midhold_rst_seg", {24'd0, seg_n}, 32'hFF);
        chk("midhold_rst_an", {29'd0, an_n}, 32'h7);
        chk("midhold_rst_flag", {31'd0, flag_led}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midhold_post_an", {29'd0, an_n}, 32'h6);
        chk("midhold_post_seg", {24'd0, seg_n}, 32'hC0);
        chk("midhold_post_ready", {31'd0, in_ready}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
